usart_rx_fifo: RTL and testbench

//  Parametrised USART receiver: oversampled mid-bit sampling, configurable word width,

---
 rtl/usart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_usart_rx_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: oversampled USART receiver feeding a show-ahead FIFO with sticky error flags.
// Define USART_RX_PARITY_EN to add a parity bit after the data bits.
module usart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 12
) (
  input  logic                          comm_clock,
  input  logic                          reset_n,
  input  logic [DIV_WIDTH-1:0]          clocks_per_bit,
  input  logic                          rx_pin,
  input  logic                          parity_odd,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overflow,
  input  logic                          clear_errors
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t                 r_state, w_next;
  logic                   r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DIV_WIDTH-1:0]   r_cnt, w_cpb, w_load_val;
  logic [BW-1:0]          r_bits;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad, r_fe, r_pe, r_ov;
  logic                   w_tick, w_load, w_shift, w_push, w_fe_set, w_pe_set;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr, r_rd;
  logic [AW:0]            r_count;
  logic                   w_pop, w_full, w_wr;

  assign w_cpb  = (clocks_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clocks_per_bit;
  assign w_tick = r_cnt <= DIV_WIDTH'(1);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = w_cpb;
    w_shift    = 1'b0;
    w_push     = 1'b0;
    w_fe_set   = 1'b0;
    w_pe_set   = 1'b0;
    case (r_state)
      IDLE: if (r_rx_prev && !r_rx_sync) begin
        w_next     = START;
        w_load     = 1'b1;
        w_load_val = w_cpb >> 1;
      end
      START: if (w_tick) begin
        w_next = r_rx_sync ? IDLE : DATA;
        w_load = !r_rx_sync;
      end
      DATA: if (w_tick) begin
        w_shift = 1'b1;
        w_load  = 1'b1;
`ifdef USART_RX_PARITY_EN
        if (r_bits == BW'(DATA_BITS - 1)) w_next = PARITY;
`else
        if (r_bits == BW'(DATA_BITS - 1)) w_next = STOP;
`endif
      end
`ifdef USART_RX_PARITY_EN
      PARITY: if (w_tick) begin
        w_next   = STOP;
        w_load   = 1'b1;
        w_pe_set = r_rx_sync != (^r_shift ^ parity_odd);
      end
`endif
      STOP: if (w_tick) begin
        w_next   = r_rx_sync ? IDLE : WAIT_HIGH;
        w_push   = r_rx_sync && !r_par_bad;
        w_fe_set = !r_rx_sync;
      end
      WAIT_HIGH: if (r_rx_sync) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifndef USART_RX_PARITY_EN
  logic w_unused;
  assign w_unused = parity_odd;
`endif

  // Synchroniser flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_rx_meta <= rx_pin;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_next;
      r_cnt     <= w_load ? w_load_val : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
      r_bits    <= (r_state == START) ? '0 : (w_shift ? r_bits + 1'b1 : r_bits);
      r_shift   <= w_shift ? {r_rx_sync, r_shift[DATA_BITS-1:1]} : r_shift;
      r_par_bad <= (r_state == START) ? 1'b0 : (r_par_bad | w_pe_set);
    end
  end

  assign w_pop  = data_valid && data_ready;
  assign w_full = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge comm_clock) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_wr    <= r_wr + AW'(w_wr);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_fe    <= w_fe_set | (r_fe & ~clear_errors);
      r_pe    <= w_pe_set | (r_pe & ~clear_errors);
      r_ov    <= (w_push && w_full && !w_pop) | (r_ov & ~clear_errors);
    end
  end

  assign data_valid    = r_count != '0;
  assign data_out      = data_valid ? r_mem[r_rd] : '0;
  assign fifo_count    = r_count;
  assign framing_error = r_fe;
  assign parity_error  = r_pe;
  assign overflow      = r_ov;
endmodule

// File: tb/tb_usart_rx_fifo.sv
// tb_usart_rx_fifo: directed frames against usart_rx_fifo, expected words kept in a queue.
module tb_usart_rx_fifo;
  logic        clk = 1'b0;
  logic        reset_n, rx_pin, parity_odd, data_ready, clear_errors;
  logic [11:0] cpb;
  logic [7:0]  data_out;
  logic        data_valid, framing_error, parity_error, overflow;
  logic [2:0]  fifo_count;
  int          total = 0, bad = 0;
  logic [7:0]  q[$];

  always #5 clk = ~clk;

  usart_rx_fifo dut (
    .comm_clock(clk), .reset_n(reset_n), .clocks_per_bit(cpb), .rx_pin(rx_pin),
    .parity_odd(parity_odd), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .fifo_count(fifo_count), .framing_error(framing_error),
    .parity_error(parity_error), .overflow(overflow), .clear_errors(clear_errors)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gp(input logic [7:0] d);
    return ^d ^ parity_odd;
  endfunction

  // One bit period of 64 clocks, entered on a falling edge; the stop sample lands on the
  // 35th rising edge of the bit, so pop_at_push raises data_ready for exactly that edge.
  task automatic bit_time(input logic b, input bit pop_at_push);
    rx_pin = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (pop_at_push && i == 33) begin
        chk("t5_head", data_out, q[0]);
        void'(q.pop_front());
        data_ready = 1'b1;
      end
      if (pop_at_push && i == 34) data_ready = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par, input bit pop_at_push);
    bit_time(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i], 1'b0);
`ifdef USART_RX_PARITY_EN
    bit_time(par, 1'b0);
`endif
    bit_time(stop, pop_at_push);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() == 0) chk({tag, "_empty"}, data_valid, 0);
    else begin
      chk({tag, "_valid"}, data_valid, 1);
      chk(tag, data_out, q.pop_front());
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
    end
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rx_pin = 1'b1; parity_odd = 1'b0; data_ready = 1'b0;
    clear_errors = 1'b0; cpb = 12'd64;
    repeat (3) @(negedge clk);
    chk("rst_valid", data_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_pe", parity_error, 0);
    chk("rst_ov", overflow, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'h75, 1'b1, gp(8'h75), 1'b0); q.push_back(8'h75);
    send(8'h8A, 1'b1, gp(8'h8A), 1'b0); q.push_back(8'h8A);
    chk("t1_count", fifo_count, 2);
    chk("t1_head", data_out, 8'h75);
    pop_chk("t1_pop0");
    pop_chk("t1_pop1");
    chk("t1_empty", data_valid, 0);

    rx_pin = 1'b0;
    repeat (20) @(negedge clk);
    rx_pin = 1'b1;
    repeat (100) @(negedge clk);
    chk("t2_count", fifo_count, 0);
    chk("t2_fe", framing_error, 0);
    chk("t2_ov", overflow, 0);

    send(8'h55, 1'b0, gp(8'h55), 1'b0);
    chk("t3_fe", framing_error, 1);
    chk("t3_count", fifo_count, 0);
    clear_flags();
    chk("t3_clr", framing_error, 0);

    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1, gp(8'(b)), 1'b0);
      if (b <= 4) q.push_back(8'(b));
    end
    chk("t4_count", fifo_count, 4);
    chk("t4_ov", overflow, 1);
    clear_flags();
    chk("t4_clr", overflow, 0);

    send(8'h06, 1'b1, gp(8'h06), 1'b1); q.push_back(8'h06);
    chk("t5_count", fifo_count, 4);
    chk("t5_ov", overflow, 0);
    for (int i = 0; i < 4; i++) pop_chk("t5_pop");
    chk("t5_empty", data_valid, 0);

`ifdef USART_RX_PARITY_EN
    send(8'h75, 1'b1, 1'b1, 1'b0); q.push_back(8'h75);
    chk("t6_par_ok", parity_error, 0);
    send(8'h75, 1'b1, 1'b0, 1'b0);
    chk("t6_par_bad", parity_error, 1);
    chk("t6_count", fifo_count, 1);
    pop_chk("t6_pop");
    clear_flags();
    chk("t6_clr", parity_error, 0);
`endif

    send(8'h3C, 1'b1, gp(8'h3C), 1'b0);
    send(8'h11, 1'b0, gp(8'h11), 1'b0);
    chk("t6_pre_count", fifo_count, 1);
    chk("t6_pre_fe", framing_error, 1);
    bit_time(1'b0, 1'b0);
    bit_time(1'b1, 1'b0);
    rx_pin = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("t6_rst_valid", data_valid, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_fe", framing_error, 0);
    chk("t6_rst_ov", overflow, 0);
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hA3, 1'b1, gp(8'hA3), 1'b0); q.push_back(8'hA3);
    chk("t6_after_count", fifo_count, 1);
    pop_chk("t6_after_pop");
    chk("t6_after_empty", data_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
